// File: rtl/i2c_av_slave.sv
// Write-only I2C target standing in for an audio codec control port: accepts
// {addr,W},{reg,d8},d[7:0] writes, strobes each word and keeps a shadow file.
module i2c_av_slave #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         REG_COUNT = 16,
  parameter int         FILT_LEN  = 3
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iI2C_SCLK,
  inout  wire        ioI2C_SDAT,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  input  logic [3:0] iRD_ADDR,
  output logic [8:0] oRD_DATA,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACKA, S_HI, S_ACKH, S_LO, S_ACKL, S_WSTOP
  } state_t;

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                scl_f_q, sda_f_q, scl_p_q, sda_p_q;
  logic                scl_rise, scl_fall, start_det, stop_det;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q, hi_q, rx_byte_d;
  logic       sda_oe_q, busy_q, reg_we_q;
  logic [6:0] reg_addr_q;
  logic [8:0] reg_data_q, rd_data_d;
  logic [8:0] shadow_q [REG_COUNT];

  always_comb begin
    scl_hist_d = (scl_hist_q << 1) | FILT_LEN'(scl_sync_q[1]);
    sda_hist_d = (sda_hist_q << 1) | FILT_LEN'(sda_sync_q[1]);
  end

  // A filtered level only moves once FILT_LEN consecutive samples agree.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so each stage takes the previous cycle's value; blocking would collapse the chain into wires.
      scl_sync_q <= {scl_sync_q[0], iI2C_SCLK};
      sda_sync_q <= {sda_sync_q[0], ioI2C_SDAT};
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      if (&scl_hist_q)       scl_f_q <= 1'b1;
      else if (~|scl_hist_q) scl_f_q <= 1'b0;
      if (&sda_hist_q)       sda_f_q <= 1'b1;
      else if (~|sda_hist_q) sda_f_q <= 1'b0;
      scl_p_q <= scl_f_q;
      sda_p_q <= sda_f_q;
    end
  end

  assign scl_rise  =  scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q &  scl_p_q;
  assign start_det =  scl_f_q &  scl_p_q &  sda_p_q & ~sda_f_q;
  assign stop_det  =  scl_f_q &  scl_p_q & ~sda_p_q &  sda_f_q;
  assign rx_byte_d = {shift_q[6:0], sda_f_q};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
    end else begin
      reg_we_q <= 1'b0;
      if (stop_det) begin
        state_q  <= S_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= S_ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b1;
      end else begin
        case (state_q)
          S_ADDR, S_HI, S_LO: begin
            if (scl_rise) begin
              shift_q   <= rx_byte_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == S_ADDR)
                  state_q <= (rx_byte_d == {DEV_ADDR, 1'b0}) ? S_ACKA : S_WSTOP;
                else if (state_q == S_HI) begin
                  hi_q    <= rx_byte_d;
                  state_q <= S_ACKH;
                end else
                  state_q <= S_ACKL;
              end
            end
          end
          // The ACK window runs from the falling edge after bit 8 to the falling edge after bit 9.
          S_ACKA, S_ACKH, S_ACKL: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
                if (state_q == S_ACKL) begin
                  reg_we_q   <= 1'b1;
                  reg_addr_q <= hi_q[7:1];
                  reg_data_q <= {hi_q[0], shift_q};
                end
              end else begin
                sda_oe_q <= 1'b0;
                state_q  <= (state_q == S_ACKA) ? S_HI :
                            (state_q == S_ACKH) ? S_LO : S_WSTOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the shadow file is a flop array with a real async reset, since both reset and register 0x0F must clear it.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
    end else if (reg_we_q) begin
      if (reg_addr_q == 7'h0F) begin
        for (int i = 0; i < REG_COUNT; i++) shadow_q[i] <= '0;
      end else begin
        for (int i = 0; i < REG_COUNT; i++)
          if (reg_addr_q == 7'(i)) shadow_q[i] <= reg_data_q;
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves rd_data_d unassigned, which would infer a latch.
    rd_data_d = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (iRD_ADDR == 4'(i)) rd_data_d = shadow_q[i];
  end

  assign ioI2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;
  assign oREG_WE    = reg_we_q;
  assign oREG_ADDR  = reg_addr_q;
  assign oREG_DATA  = reg_data_q;
  assign oRD_DATA   = rd_data_d;
  assign oBUSY      = busy_q;

endmodule

// File: tb/tb_i2c_av_slave.sv
// Directed bench for i2c_av_slave: a bit-banged I2C initiator, a strobe
// scoreboard and a shadow-file model.
module tb_i2c_av_slave;

  localparam int Q = 10;  // iCLK cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [3:0] rd_addr = '0;
  wire        sda;
  logic       reg_we, busy;
  logic [6:0] reg_addr;
  logic [8:0] reg_data, rd_data;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_av_slave dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iI2C_SCLK  (scl),
    .ioI2C_SDAT (sda),
    .oREG_WE    (reg_we),
    .oREG_ADDR  (reg_addr),
    .oREG_DATA  (reg_data),
    .iRD_ADDR   (rd_addr),
    .oRD_DATA   (rd_data),
    .oBUSY      (busy)
  );

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [8:0] model [16];
  int         total = 0, bad = 0, we_cnt = 0, exp_we = 0;
  logic [6:0] last_addr = '0;
  logic [8:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && reg_we === 1'b1) begin
      we_cnt++;
      check("strobe_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", reg_addr, mon_e.addr);
        check("strobe_data", reg_data, mon_e.data);
      end
    end
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      m_sda_low = ~b[i]; wait_q();
      scl = 1'b1;        wait_q(); wait_q();
      scl = 1'b0;        wait_q();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    ack = (sda === 1'b0);
    wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic model_write(input logic [6:0] a, input logic [8:0] d);
    exp_q.push_back({a, d});
    exp_we++;
    last_addr = a;
    last_data = d;
    if (a == 7'h0F) foreach (model[i]) model[i] = '0;
    else if (a < 7'd16) model[a[3:0]] = d;
  endtask

  task automatic write_word(input logic [7:0] hi, input logic [7:0] lo,
                            input bit do_stop, input string tag);
    logic ack;
    i2c_start();
    send_byte(8'h34, ack); check({tag, "_ack_dev"}, ack, 1);
    send_byte(hi, ack);    check({tag, "_ack_hi"}, ack, 1);
    model_write(hi[7:1], {hi[0], lo});
    send_byte(lo, ack);    check({tag, "_ack_lo"}, ack, 1);
    if (do_stop) i2c_stop();
  endtask

  task automatic check_strobes(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_we_count"}, we_cnt, exp_we);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_held_addr"}, reg_addr, last_addr);
    check({tag, "_held_data"}, reg_data, last_data);
  endtask

  task automatic check_shadow(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s_sh%0d", tag, i), rd_data, model[i]);
    end
  endtask

  initial begin
    logic ack;
    foreach (model[i]) model[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", reg_we, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_data", reg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);
    check("rst_rd", rd_data, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Basic writes, including data bit 8 set
    write_word(8'h00, 8'h9A, 1'b1, "w0");
    check("w0_busy_after_stop", busy, 0);
    check_strobes("w0");
    write_word(8'h07, 8'h80, 1'b1, "w3");
    check_strobes("w3");
    check_shadow("s1");

    // Address 9, out-of-range address 0x20, then codec reset register
    write_word(8'h12, 8'h01, 1'b1, "w9");
    write_word(8'h40, 8'h55, 1'b1, "w32");
    check_strobes("w32");
    check_shadow("s2");
    write_word(8'h1E, 8'h00, 1'b1, "clr");
    check_strobes("clr");
    check_shadow("s3");

    // Wrong device address, then read request
    i2c_start();
    send_byte(8'h36, ack); check("nack_36", ack, 0);
    check("busy_36", busy, 1);
    i2c_stop();
    check("idle_36", busy, 0);
    i2c_start();
    send_byte(8'h35, ack); check("nack_35", ack, 0);
    check("busy_35", busy, 1);
    i2c_stop();
    check("idle_35", busy, 0);
    check_strobes("badaddr");

    // Partial word discarded; extra byte after a full word is NACKed
    i2c_start();
    send_byte(8'h34, ack); check("part_ack_dev", ack, 1);
    send_byte(8'h08, ack); check("part_ack_hi", ack, 1);
    i2c_stop();
    check_strobes("partial");
    write_word(8'h06, 8'h33, 1'b0, "w3b");
    send_byte(8'hFF, ack); check("extra_nack", ack, 0);
    i2c_stop();
    check_strobes("extra");
    check_shadow("s4");

    // Repeated START after the HI byte
    i2c_start();
    send_byte(8'h34, ack); check("rs_ack_dev", ack, 1);
    send_byte(8'h0A, ack); check("rs_ack_hi", ack, 1);
    write_word(8'h04, 8'h79, 1'b1, "rs");
    check_strobes("rs");
    check_shadow("s5");

    // One-iCLK SDA glitches while SCL is high
    @(negedge clk) m_sda_low = 1'b1;
    @(negedge clk) m_sda_low = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_no_start", busy, 0);
    i2c_start();
    check("glitch_started", busy, 1);
    m_sda_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    @(negedge clk) m_sda_low = 1'b0;
    @(negedge clk) m_sda_low = 1'b1;
    wait_q();
    check("glitch_no_stop", busy, 1);
    scl = 1'b0; wait_q();
    i2c_stop();
    check("glitch_stopped", busy, 0);
    check_strobes("glitch");

    // Reset while the target is driving an ACK
    i2c_start();
    send_bits(8'h34);
    m_sda_low = 1'b0;
    @(negedge clk);
    check("ack_driven", sda, 0);
    rst_n = 1'b0;
    #1;
    check("rst_ack_sda", sda, 1);
    check("rst_ack_busy", busy, 0);
    check("rst_ack_addr", reg_addr, 0);
    check("rst_ack_data", reg_data, 0);
    foreach (model[i]) model[i] = '0;
    last_addr = '0;
    last_data = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    scl = 1'b1;
    repeat (20) @(negedge clk);
    check_shadow("s6");
    write_word(8'h02, 8'h5A, 1'b1, "post");
    check_strobes("post");
    check_shadow("s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
